ahb_console_master: RTL

AHB_CONSOLE_MASTER -- requirements
Module: ahb_console_master

---
 rtl/ahb_pkg.sv | 22 ++
 rtl/console_fifo.sv | 46 ++++
 rtl/ahb_console_master.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the console master's bus-sequencing state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // ST_ADDR_DATA overlaps the data phase of one write with the address phase of the next.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ADDR_DATA
    } state_t;

endpackage

// File: rtl/console_fifo.sv
// Character FIFO with power-of-two depth; pointers wrap naturally, occupancy is registered.
module console_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rstN,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/ahb_console_master.sv
// Drains a character FIFO into single-beat AHB word writes, pipelining address and data phases.
// Optional macro AHB_CONSOLE_MASTER_CRLF_EN expands each LF into a CR,LF pair on the bus.
module ahb_console_master
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic [31:0]                   HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [31:0]                   HWDATA,
    input  logic                          HREADY,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

    state_t        r_state;
    state_t        w_nextState;
    logic          r_live;
    logic [7:0]    r_addrByte;
    logic [7:0]    r_dataByte;
    logic          w_take;
    logic          w_haveByte;
    logic [7:0]    w_nextByte;
    logic          w_pop;
    logic          w_push;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;

    // r_live keeps in_ready low while reset is held, without a combinational path from HRESETn.
    assign in_ready = r_live & (w_count < FULL_COUNT);
    assign w_push   = in_valid & in_ready;

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (HCLK),
        .i_rstN  (HRESETn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (in_data),
        .o_rdata (w_head),
        .o_count (w_count)
    );

`ifdef AHB_CONSOLE_MASTER_CRLF_EN
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    // A popped LF is issued as CR first; the LF itself is replayed from this flag, not the FIFO.
    logic r_pendLf;

    assign w_haveByte = r_pendLf | (w_count != '0);
    assign w_nextByte = r_pendLf ? CHAR_LF : ((w_head == CHAR_LF) ? CHAR_CR : w_head);
    assign w_pop      = w_take & ~r_pendLf;

    always_ff @(posedge HCLK) begin
        if (!HRESETn)    r_pendLf <= 1'b0;
        else if (w_take) r_pendLf <= ~r_pendLf & (w_head == CHAR_LF);
    end
`else
    assign w_haveByte = (w_count != '0);
    assign w_nextByte = w_head;
    assign w_pop      = w_take;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_live     <= 1'b0;
            r_addrByte <= '0;
            r_dataByte <= '0;
        end else begin
            r_state <= w_nextState;
            r_live  <= 1'b1;
            if (w_take) r_addrByte <= w_nextByte;
            if (((r_state == ST_ADDR) || (r_state == ST_ADDR_DATA)) && HREADY)
                r_dataByte <= r_addrByte;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_haveByte) begin
                    w_take      = 1'b1;
                    w_nextState = ST_ADDR;
                end
            end
            ST_ADDR, ST_ADDR_DATA: begin
                if (HREADY) begin
                    if (w_haveByte) begin
                        w_take      = 1'b1;
                        w_nextState = ST_ADDR_DATA;
                    end else begin
                        w_nextState = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    if (w_haveByte) begin
                        w_take      = 1'b1;
                        w_nextState = ST_ADDR;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HADDR  = '0;
        HWDATA = '0;
        case (r_state)
            ST_ADDR: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = BASE_ADDR;
            end
            ST_DATA: begin
                HWDATA = {24'h0, r_dataByte};
            end
            ST_ADDR_DATA: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = 1'b1;
                HADDR  = BASE_ADDR;
                HWDATA = {24'h0, r_dataByte};
            end
            default: ;
        endcase
    end

    assign HSIZE      = HSIZE_WORD;
    assign HBURST     = HBURST_SINGLE;
    assign busy       = (r_state != ST_IDLE) | (w_count != '0);
    assign fifo_count = w_count;

endmodule
